mem_responder_ram: RTL and testbench



---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_intf.sv | 21 ++
 rtl/mem_responder_fifo.sv | 76 +++++++
 rtl/mem_responder_ram.sv | 158 +++++++++++++++
 tb/tb_mem_responder_ram.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
//   MEM_DATA_WIDTH        : word width carried by the pipeline entry type
//   mem_responder_entry_t : one pipeline slot (valid + data)
//   mem_word_index()      : byte address -> RAM word index
package mem_pkg;

  localparam int unsigned MEM_DATA_WIDTH = 32;

  typedef struct packed {
    logic                      valid;
    logic [MEM_DATA_WIDTH-1:0] data;
  } mem_responder_entry_t;

  // Drops the two byte-offset bits and keeps words_log2 bits of word index;
  // higher address bits alias onto the same word.
  function automatic int unsigned mem_word_index(input logic [63:0] addr,
                                                 input int unsigned words_log2);
    logic [63:0] w_mask;
    w_mask = (64'd1 << words_log2) - 64'd1;
    return 32'((addr >> 2) & w_mask);
  endfunction

endpackage

// File: rtl/mem_intf.sv
// Request/result link between a core memory port and its responder.
//   valid/ready        : handshake
//   read_enable        : read request
//   write_enable       : per-byte write strobes
//   addr               : byte address
//   data               : write data (request) or read data (result)
// Modport "in" is the receiving side, "out" the sending side.
interface mem_intf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic                    read_enable;
  logic [DATA_WIDTH/8-1:0] write_enable;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   data;

  modport in  (input  valid, read_enable, write_enable, addr, data, output ready);
  modport out (output valid, read_enable, write_enable, addr, data, input  ready);
endinterface

// File: rtl/mem_responder_fifo.sv
// First-word-fallthrough FIFO with same-cycle bypass when empty.
//   clk, rst     : clock, async active-high reset (empties the FIFO)
//   i_push       : push i_push_data this cycle
//   i_pop        : consume the head this cycle (only meaningful when o_valid)
//   o_valid      : head available (stored entry, or the entry being pushed)
//   o_data       : head data
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
//   o_count      : stored entry count
module mem_responder_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0],
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  T              i_push_data,
  input  logic          i_pop,
  output logic          o_valid,
  output T              o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

  // An entry pushed into an empty FIFO is presented immediately; if it is
  // also popped in that cycle it never touches storage.
  assign o_valid = !o_empty || i_push;
  assign o_data  = o_empty ? i_push_data : r_mem[r_rd];
  assign w_wr    = i_push && !(o_empty && i_pop);
  assign w_rd    = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wr <= ptr_inc(r_wr);
      end
      if (w_rd) begin
        r_rd <= ptr_inc(r_rd);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder_ram.sv
// Synchronous RAM responder on the far end of a mem_intf link.
//   clk, rst : clock, async active-high reset (drops all in-flight responses)
//   request  : mem_intf.in  - read/write requests, byte-masked writes
//   result   : mem_intf.out - one in-order response per accepted request,
//                             data = word contents before that request's write
//   busy     : any response in flight
// Credit counter covers pipeline plus FIFO, so the pipeline never stalls and
// request.ready depends only on registered state.
module mem_responder_ram
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned WORDS_LOG2 = 12,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic  clk,
  input  logic  rst,
  mem_intf.in   request,
  mem_intf.out  result,
  output logic  busy
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned WORDS = 1 << WORDS_LOG2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH != MEM_DATA_WIDTH) begin : g_bad_width
    $error("mem_responder_ram: DATA_WIDTH must be a byte multiple matching mem_pkg");
  end
  if (LATENCY < 1 || FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
    $error("mem_responder_ram: need LATENCY >= 1 and FIFO_DEPTH >= LATENCY+1");
  end
  if (ADDR_WIDTH > 64 || ADDR_WIDTH < WORDS_LOG2 + 2) begin : g_bad_addr
    $error("mem_responder_ram: ADDR_WIDTH out of range");
  end

  logic [DATA_WIDTH-1:0] r_mem [WORDS];
  logic [WORDS_LOG2-1:0] w_idx;
  logic                  w_accept;
  logic                  w_pop;
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  mem_responder_entry_t  w_s1;
  mem_responder_entry_t  w_last;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  r_ready;
  logic                  w_fifo_valid;
  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;

  assign w_idx         = WORDS_LOG2'(mem_word_index(64'(request.addr), WORDS_LOG2));
  assign w_accept      = request.valid && r_ready;
  assign request.ready = r_ready;

  // Stage 1: registered read of the old word, byte-lane writes at the same edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_data <= r_mem[w_idx];
      for (int unsigned i = 0; i < NB; i++) begin
        if (request.write_enable[i]) begin
          r_mem[w_idx][8*i +: 8] <= request.data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
    end
  end

  assign w_s1 = '{valid: r_s1_valid, data: r_s1_data};

  // Stages 2..LATENCY advance every cycle; credit guarantees the FIFO has room.
  if (LATENCY > 1) begin : g_tail
    mem_responder_entry_t r_tail [LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned i = 0; i < LATENCY - 1; i++) begin
          r_tail[i] <= '0;
        end
      end else begin
        r_tail[0] <= w_s1;
        for (int unsigned i = 1; i < LATENCY - 1; i++) begin
          r_tail[i] <= r_tail[i-1];
        end
      end
    end

    assign w_last = r_tail[LATENCY-2];
  end else begin : g_no_tail
    assign w_last = w_s1;
  end

  mem_responder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [DATA_WIDTH-1:0])
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_last.valid),
    .i_push_data (w_last.data),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  assign result.valid        = w_fifo_valid;
  assign result.data         = w_fifo_data;
  assign result.read_enable  = 1'b0;
  assign result.write_enable = '0;
  assign result.addr         = '0;
  assign w_pop               = w_fifo_valid && result.ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_accept && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_accept && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Ready is registered from the next count so it is low throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_ready <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < DEPTH_C);
    end
  end

  assign busy = (r_count != '0);

  a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= DEPTH_C);
  a_fifo_room:   assert property (@(posedge clk) disable iff (rst)
                   !(w_fifo_full && w_last.valid && !w_pop));
  a_fifo_credit: assert property (@(posedge clk) disable iff (rst) w_fifo_count <= r_count);
  a_empty_pass:  assert property (@(posedge clk) disable iff (rst)
                   w_fifo_empty |-> (w_fifo_valid == w_last.valid));

endmodule

// File: tb/tb_mem_responder_ram.sv
// Directed bench: u_dut (LATENCY=1, FIFO_DEPTH=4) and u_dut3 (LATENCY=3, FIFO_DEPTH=4).
module tb_mem_responder_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy1;
  logic busy3;

  int n_checks = 0;
  int n_err    = 0;

  mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) req1 ();
  mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) res1 ();
  mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) req3 ();
  mem_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) res3 ();

  mem_responder_ram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .WORDS_LOG2 (12),
    .LATENCY    (1),
    .FIFO_DEPTH (4),
    .INIT_FILE  ("")
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .request (req1),
    .result  (res1),
    .busy    (busy1)
  );

  mem_responder_ram #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .WORDS_LOG2 (12),
    .LATENCY    (3),
    .FIFO_DEPTH (4),
    .INIT_FILE  ("")
  ) u_dut3 (
    .clk     (clk),
    .rst     (rst),
    .request (req3),
    .result  (res3),
    .busy    (busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on u_dut, held until accepted (bounded).
  task automatic send1(input logic rd, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req1.valid        = 1'b1;
    req1.read_enable  = rd;
    req1.write_enable = we;
    req1.addr         = addr;
    req1.data         = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("send1_timeout", 32'(ok), 32'd1);
    end
    @(posedge clk); #1;
    req1.valid = 1'b0;
  endtask

  task automatic wait_idle1(input string name);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy1) begin
        idle = 1'b1;
        break;
      end
    end
    check(name, 32'(idle), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int idx;
    logic idle3;

    vecs[0]  = '{1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'h5, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 32'h1122_3344};
    vecs[4]  = '{1'b1, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 4'hF, 32'h0000_4008, 32'h5A5A_5A5A, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 4'h0, 32'h0000_0008, 32'h0,         1'b1, 32'h5A5A_5A5A};
    vecs[7]  = '{1'b1, 4'h0, 32'h0000_000B, 32'h0,         1'b1, 32'h5A5A_5A5A};
    vecs[8]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 4'h8, 32'h0000_0010, 32'h0102_0304, 1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h01AD_BEEF};
    vecs[11] = '{1'b0, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 32'h01AD_BEEF};
    vecs[12] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h01AD_BEEF};

    req1.valid = 1'b0; req1.read_enable = 1'b0; req1.write_enable = '0;
    req1.addr = '0; req1.data = '0; res1.ready = 1'b1;
    req3.valid = 1'b0; req3.read_enable = 1'b0; req3.write_enable = '0;
    req3.addr = '0; req3.data = '0; res3.ready = 1'b1;

    // Reset state
    #2;
    check("rst_req_ready1", 32'(req1.ready), 32'd0);
    check("rst_res_valid1", 32'(res1.valid), 32'd0);
    check("rst_busy1",      32'(busy1),      32'd0);
    check("rst_req_ready3", 32'(req3.ready), 32'd0);
    check("rst_res_valid3", 32'(res3.valid), 32'd0);
    check("rst_busy3",      32'(busy3),      32'd0);
    #10 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready1", 32'(req1.ready), 32'd1);
    check("post_rst_ready3", 32'(req3.ready), 32'd1);

    // Back-to-back vectors, result for vector k-1 visible while k is driven
    for (int k = 0; k <= NV; k++) begin
      @(posedge clk); #1;
      if (k < NV) begin
        req1.valid        = 1'b1;
        req1.read_enable  = vecs[k].rd;
        req1.write_enable = vecs[k].we;
        req1.addr         = vecs[k].addr;
        req1.data         = vecs[k].wdata;
      end else begin
        req1.valid = 1'b0;
      end
      @(negedge clk);
      if (k < NV) begin
        check($sformatf("vec%0d_req_ready", k), 32'(req1.ready), 32'd1);
      end
      if (k > 0) begin
        check($sformatf("vec%0d_res_valid", k - 1), 32'(res1.valid), 32'd1);
        if (vecs[k-1].chk) begin
          check($sformatf("vec%0d_res_data", k - 1), res1.data, vecs[k-1].exp);
        end
      end
    end

    // Backpressure and credit
    for (int i = 0; i < 6; i++) begin
      send1(1'b0, 4'hF, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    end
    wait_idle1("bp_pre_idle");
    accepts = 0;
    idx = 0;
    @(posedge clk); #1;
    res1.ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (idx < 6) begin
        req1.valid = 1'b1; req1.read_enable = 1'b1; req1.write_enable = '0;
        req1.addr = 32'h100 + 32'(4 * idx);
      end else begin
        req1.valid = 1'b0;
      end
      @(negedge clk);
      if (req1.valid && req1.ready) begin
        accepts++;
        idx++;
      end
    end
    @(posedge clk); #1;
    req1.valid = 1'b0;
    res1.ready = 1'b1;
    @(negedge clk);
    check("bp_accepts",   32'(accepts),    32'd4);
    check("bp_req_ready", 32'(req1.ready), 32'd0);
    check("bp_busy",      32'(busy1),      32'd1);
    check("bp_res0_valid", 32'(res1.valid), 32'd1);
    check("bp_res0_data",  res1.data,       32'hA0);
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("bp_res%0d_valid", j), 32'(res1.valid), 32'd1);
      check($sformatf("bp_res%0d_data", j),  res1.data,       32'hA0 + 32'(j));
      if (j == 1) begin
        check("bp_ready_after_pop", 32'(req1.ready), 32'd1);
      end
    end
    @(negedge clk);
    check("bp_no_dup_valid", 32'(res1.valid), 32'd0);
    check("bp_idle_busy",    32'(busy1),      32'd0);

    // Reset mid-operation
    @(posedge clk); #1;
    res1.ready = 1'b0;
    send1(1'b1, 4'h0, 32'h100, 32'h0);
    send1(1'b1, 4'h0, 32'h104, 32'h0);
    send1(1'b1, 4'h0, 32'h108, 32'h0);
    @(negedge clk);
    check("mid_busy_before", 32'(busy1), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_res_valid", 32'(res1.valid), 32'd0);
    check("mid_rst_busy",      32'(busy1),      32'd0);
    check("mid_rst_req_ready", 32'(req1.ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    res1.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("mid_stale%0d", c), 32'(res1.valid), 32'd0);
    end
    send1(1'b1, 4'h0, 32'h104, 32'h0);
    @(negedge clk);
    check("mid_rd104_valid", 32'(res1.valid), 32'd1);
    check("mid_rd104_data",  res1.data,       32'hA1);
    send1(1'b1, 4'h0, 32'h010, 32'h0);
    @(negedge clk);
    check("mid_rd010_valid", 32'(res1.valid), 32'd1);
    check("mid_rd010_data",  res1.data,       32'h01AD_BEEF);

    // Full throughput on LATENCY=3: preload word i = i, then 100 reads
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      req3.valid = 1'b1; req3.read_enable = 1'b0; req3.write_enable = 4'hF;
      req3.addr = 32'(4 * i); req3.data = 32'(i);
    end
    @(posedge clk); #1;
    req3.valid = 1'b0;
    idle3 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy3) begin
        idle3 = 1'b1;
        break;
      end
    end
    check("tp_pre_idle", 32'(idle3), 32'd1);
    for (int c = 0; c < 104; c++) begin
      @(posedge clk); #1;
      if (c < 100) begin
        req3.valid = 1'b1; req3.read_enable = 1'b1; req3.write_enable = '0;
        req3.addr = 32'(4 * c);
      end else begin
        req3.valid = 1'b0;
      end
      @(negedge clk);
      if (c < 100) begin
        check($sformatf("tp_req_ready%0d", c), 32'(req3.ready), 32'd1);
      end
      if (c >= 3 && c < 103) begin
        check($sformatf("tp_res_valid%0d", c - 3), 32'(res3.valid), 32'd1);
        check($sformatf("tp_res_data%0d", c - 3),  res3.data,       32'(c - 3));
      end else begin
        check($sformatf("tp_res_idle_c%0d", c), 32'(res3.valid), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
